// File: rtl/engagement_sequencer_if.sv
// Engagement sequencer bus: mission request, radar handshake, scan
// configuration and sequencer status grouped for a single port.
interface engagement_sequencer_if;
  logic        mission_start;
  logic [1:0]  ARTAU_state;
  logic        threat_detected;
  logic        safe_to_engage;
  logic        emergency_landing_alert;
  logic [15:0] scan_interval;
  logic [7:0]  scan_limit;
  logic        scan_for_target;
  logic        engage_fire;
  logic        abort;
  logic        mission_active;
  logic [7:0]  scan_count;
  logic [2:0]  seq_state;

  modport slave (
    input  mission_start, ARTAU_state, threat_detected, safe_to_engage,
           emergency_landing_alert, scan_interval, scan_limit,
    output scan_for_target, engage_fire, abort, mission_active,
           scan_count, seq_state
  );

  modport master (
    output mission_start, ARTAU_state, threat_detected, safe_to_engage,
           emergency_landing_alert, scan_interval, scan_limit,
    input  scan_for_target, engage_fire, abort, mission_active,
           scan_count, seq_state
  );
endinterface

// File: rtl/engagement_sequencer.sv
// Engagement sequencer: issues radar scans, evaluates results, commands
// engagement after enough confirming scans, aborts on weather emergency
// or radar watchdog timeout. All outputs are registered.
// Optional macro SEQ_DUAL_CONFIRM_EN: two consecutive confirming scans are
// needed before ENGAGE (default: one).
module engagement_sequencer #(
  parameter int unsigned WDOG_CYCLES = 1000
) (
  input  logic                  CLK,
  input  logic                  RST,
  engagement_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_WAIT   = 3'd2,
    S_HOLD   = 3'd3,
    S_ENGAGE = 3'd4,
    S_ABORT  = 3'd5
  } state_e;

`ifdef SEQ_DUAL_CONFIRM_EN
  localparam logic [1:0] CONFIRM_REQ = 2'd2;
`else
  localparam logic [1:0] CONFIRM_REQ = 2'd1;
`endif

  // Last watchdog count value at which WAIT is still tolerated.
  localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES) - 32'd1;

  state_e      state_q, state_d;
  logic [7:0]  scan_count_q, scan_count_d;
  logic [1:0]  confirm_q, confirm_d;
  logic        busy_q, busy_d;
  logic [31:0] wdog_q, wdog_d;
  logic [15:0] ivl_q, ivl_d;
  logic        scan_q, engage_q, abort_q, active_q;
  logic        done_s;
  logic [1:0]  confirm_inc_s;
  logic        interval_done_s;
  logic        limit_hit_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign done_s          = busy_q && (bus.ARTAU_state == 2'b00);
  assign confirm_inc_s   = confirm_q + 2'd1;
  assign interval_done_s = ({1'b0, ivl_q} + 17'd1) >= {1'b0, bus.scan_interval};
  assign limit_hit_s     = (bus.scan_limit != 8'd0) && (scan_count_q == bus.scan_limit);

  // Next-state and counter update; alert outranks mission drop, which
  // outranks the normal flow.
  always_comb begin
    state_d      = state_q;
    scan_count_d = scan_count_q;
    confirm_d    = confirm_q;
    busy_d       = busy_q;
    wdog_d       = wdog_q;
    ivl_d        = ivl_q;
    case (state_q)
      S_IDLE: begin
        if (bus.mission_start && !bus.emergency_landing_alert) begin
          state_d      = S_SCAN;
          scan_count_d = 8'd1;
          confirm_d    = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (bus.emergency_landing_alert) begin
          state_d = S_ABORT;
        end else if (!bus.mission_start) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          busy_d  = 1'b0;
          wdog_d  = 32'd0;
        end
      end
      S_WAIT: begin
        if (bus.emergency_landing_alert) begin
          state_d = S_ABORT;
        end else if (!bus.mission_start) begin
          state_d = S_IDLE;
        end else if (done_s) begin
          ivl_d = 16'd0;
          if (bus.threat_detected && bus.safe_to_engage) begin
            confirm_d = confirm_inc_s;
            if (confirm_inc_s == CONFIRM_REQ) begin
              state_d = S_ENGAGE;
            end else begin
              state_d = S_HOLD;
            end
          end else begin
            confirm_d = 2'd0;
            state_d   = S_HOLD;
          end
        end else if (wdog_q >= WDOG_LAST) begin
          state_d = S_ABORT;
        end else begin
          wdog_d = wdog_q + 32'd1;
          if (bus.ARTAU_state != 2'b00) begin
            busy_d = 1'b1;
          end else begin
            busy_d = busy_q;
          end
        end
      end
      S_HOLD: begin
        if (bus.emergency_landing_alert) begin
          state_d = S_ABORT;
        end else if (!bus.mission_start) begin
          state_d = S_IDLE;
        end else if (limit_hit_s) begin
          state_d = S_IDLE;
        end else if (interval_done_s) begin
          state_d      = S_SCAN;
          scan_count_d = sat_inc8(scan_count_q);
        end else begin
          ivl_d = ivl_q + 16'd1;
        end
      end
      S_ENGAGE: begin
        if (bus.emergency_landing_alert) begin
          state_d = S_ABORT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        if (!bus.emergency_landing_alert && !bus.mission_start) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ABORT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and outputs registered together; outputs follow the
  // state being entered so pulses line up with the SCAN/ENGAGE cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      scan_count_q <= 8'd0;
      confirm_q    <= 2'd0;
      busy_q       <= 1'b0;
      wdog_q       <= 32'd0;
      ivl_q        <= 16'd0;
      scan_q       <= 1'b0;
      engage_q     <= 1'b0;
      abort_q      <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_count_q <= scan_count_d;
      confirm_q    <= confirm_d;
      busy_q       <= busy_d;
      wdog_q       <= wdog_d;
      ivl_q        <= ivl_d;
      scan_q       <= (state_d == S_SCAN);
      engage_q     <= (state_d == S_ENGAGE);
      abort_q      <= (state_d == S_ABORT);
      active_q     <= (state_d != S_IDLE) && (state_d != S_ABORT);
    end
  end

  assign bus.scan_for_target = scan_q;
  assign bus.engage_fire     = engage_q;
  assign bus.abort           = abort_q;
  assign bus.mission_active  = active_q;
  assign bus.scan_count      = scan_count_q;
  assign bus.seq_state       = state_q;

endmodule
